// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes,
// EX operand forward-select codes and small register-match helpers.
package hazard_controller_pkg;

    // Controller FSM state encodings
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [15:0] STALL_CYCLES_MAX = 16'hFFFF;

    // True when a real (non-$0) destination feeds either ID source register
    function automatic logic rd_hits(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

    // Operand select for one EX source: the younger MEM result wins over WB
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input logic [4:0] mem_rd,
                                              input logic       mem_we,
                                              input logic [4:0] wb_rd,
                                              input logic       wb_we);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) return FWD_MEM;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_controller_forwarding_unit.sv
// Combinational EX-stage forwarding: picks register file, WB or MEM result
// for each ALU source operand.
module forwarding_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] exRs,
    input  logic [4:0] exRt,
    input  logic [4:0] memRd,
    input  logic       memRegWrite,
    input  logic [4:0] wbRd,
    input  logic       wbRegWrite,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB
);

    assign forwardA = fwd_select(exRs, memRd, memRegWrite, wbRd, wbRegWrite);
    assign forwardB = fwd_select(exRt, memRd, memRegWrite, wbRd, wbRegWrite);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: detects load-use and branch data hazards,
// inserts bubbles through a small RUN/STALL/MEMWAIT FSM, freezes the pipe
// while data memory is busy, and counts stalled cycles.
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idIsBranch,
    input  logic        isBranch,
    input  logic        jump,
    input  logic [4:0]  exRd,
    input  logic        exRegWrite,
    input  logic        exMemRead,
    input  logic [4:0]  exRs,
    input  logic [4:0]  exRt,
    input  logic [4:0]  memRd,
    input  logic        memRegWrite,
    input  logic        memMemRead,
    input  logic [4:0]  wbRd,
    input  logic        wbRegWrite,
    input  logic        memReq,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        pipeFreeze,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic [15:0] stallCycles
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  ret_q, ret_d;          // state preempted by MEMWAIT
    logic [1:0]  cnt_q, cnt_d;          // remaining STALL cycles
    logic [15:0] stall_cycles_q;

    logic        ex_hit, mem_hit;
    logic        h_load_use, h_branch_alu, h_branch_load_ex, h_branch_load_mem;
    logic [1:0]  bubbles;
    logic        mem_stall;
    logic [1:0]  resume_state;
    logic [1:0]  fwd_a, fwd_b;

    assign ex_hit  = rd_hits(exRd, idRs, idRt);
    assign mem_hit = rd_hits(memRd, idRs, idRt);

    assign h_load_use        = exMemRead && ex_hit;
    assign h_branch_alu      = idIsBranch && exRegWrite && !exMemRead && ex_hit;
    assign h_branch_load_ex  = idIsBranch && exMemRead && ex_hit;
    assign h_branch_load_mem = idIsBranch && memMemRead && mem_hit;

    // Worst-case bubble requirement over all active hazards
    assign bubbles = h_branch_load_ex ? 2'd2 :
                     (h_load_use || h_branch_alu || h_branch_load_mem) ? 2'd1 : 2'd0;

    // An outstanding access keeps the pipe frozen until memReady arrives
    assign mem_stall    = !memReady && (memReq || (state_q == ST_MEMWAIT));
    assign resume_state = (state_q == ST_MEMWAIT) ? ret_q : state_q;

    forwarding_unit u_forwarding_unit (
        .exRs        (exRs),
        .exRt        (exRt),
        .memRd       (memRd),
        .memRegWrite (memRegWrite),
        .wbRd        (wbRd),
        .wbRegWrite  (wbRegWrite),
        .forwardA    (fwd_a),
        .forwardB    (fwd_b)
    );

    assign forwardA    = rst ? FWD_RF : fwd_a;
    assign forwardB    = rst ? FWD_RF : fwd_b;
    assign stallCycles = stall_cycles_q;

    // Sequencing outputs and FSM next state. The hazard-detection cycle is
    // itself the first bubble, so STALL holds only the bubbles beyond it.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        pipeFreeze = 1'b0;
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;

        if (rst) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            state_d    = ST_RUN;
            ret_d      = ST_RUN;
            cnt_d      = 2'd0;
        end else if (mem_stall) begin
            pipeFreeze = 1'b1;
            state_d    = ST_MEMWAIT;
            if (state_q != ST_MEMWAIT) ret_d = state_q;
        end else if (resume_state == ST_STALL) begin
            idExBubble = 1'b1;
            if (cnt_q > 2'd1) begin
                cnt_d   = cnt_q - 2'd1;
                state_d = ST_STALL;
            end else begin
                cnt_d   = 2'd0;
                state_d = ST_RUN;
            end
        end else if (bubbles != 2'd0) begin
            idExBubble = 1'b1;
            cnt_d      = bubbles - 2'd1;
            state_d    = (bubbles > 2'd1) ? ST_STALL : ST_RUN;
        end else begin
            pcWrite   = 1'b1;
            ifIdWrite = 1'b1;
            ifIdFlush = isBranch || jump;
            state_d   = ST_RUN;
        end
    end

    // FSM state, preempted-state and bubble counter registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 16'd0;
        end else if (!pcWrite && (stall_cycles_q != STALL_CYCLES_MAX)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the stimulus process pushes the
// hand-computed expected outputs for every cycle it drives, and a monitor
// pops and compares them on the falling edge.
module tb_hazard_controller;

    bit          clk;
    logic        rst;
    logic [4:0]  idRs, idRt, exRd, exRs, exRt, memRd, wbRd;
    logic        idIsBranch, isBranch, jump, exRegWrite, exMemRead;
    logic        memRegWrite, memMemRead, wbRegWrite, memReq, memReady;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze;
    logic [1:0]  forwardA, forwardB;
    logic [15:0] stallCycles;

    // {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_FLUSH = 5'b11100;
    localparam logic [4:0] C_BUB   = 5'b00010;
    localparam logic [4:0] C_FRZ   = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    typedef struct {
        string       name;
        logic [4:0]  ctl;
        logic [3:0]  fwd;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic [15:0] sc_exp;

    hazard_controller dut (
        .clk (clk), .rst (rst),
        .idRs (idRs), .idRt (idRt), .idIsBranch (idIsBranch),
        .isBranch (isBranch), .jump (jump),
        .exRd (exRd), .exRegWrite (exRegWrite), .exMemRead (exMemRead),
        .exRs (exRs), .exRt (exRt),
        .memRd (memRd), .memRegWrite (memRegWrite), .memMemRead (memMemRead),
        .wbRd (wbRd), .wbRegWrite (wbRegWrite),
        .memReq (memReq), .memReady (memReady),
        .pcWrite (pcWrite), .ifIdWrite (ifIdWrite), .ifIdFlush (ifIdFlush),
        .idExBubble (idExBubble), .pipeFreeze (pipeFreeze),
        .forwardA (forwardA), .forwardB (forwardB),
        .stallCycles (stallCycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Push one cycle's expectation, update the stall-count model, advance a cycle
    task automatic cycle(input string name, input logic [4:0] ctl,
                         input logic [1:0] fa = 2'd0, input logic [1:0] fb = 2'd0);
        exp_t e;
        e.name = name;
        e.ctl  = ctl;
        e.fwd  = {fa, fb};
        e.sc   = sc_exp;
        sb.push_back(e);
        if (rst) sc_exp = 16'd0;
        else if (!ctl[4] && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        idRs = 0; idRt = 0; idIsBranch = 0; isBranch = 0; jump = 0;
        exRd = 0; exRegWrite = 0; exMemRead = 0; exRs = 0; exRt = 0;
        memRd = 0; memRegWrite = 0; memMemRead = 0;
        wbRd = 0; wbRegWrite = 0; memReq = 0; memReady = 1;
    endtask

    // Monitor: compare the oldest expectation against the DUT mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " ctl"},
                      {27'd0, pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze},
                      {27'd0, e.ctl});
                check({e.name, " fwd"}, {28'd0, forwardA, forwardB}, {28'd0, e.fwd});
                check({e.name, " stallCycles"}, {16'd0, stallCycles}, {16'd0, e.sc});
            end
        end
    end

    // Absolute time bound so the run always terminates
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks = 0; failures = 0; sc_exp = 16'd0;
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset forces fixed outputs despite live hazard and forwarding inputs
        memRd = 5; memRegWrite = 1; exRs = 5; exRt = 5; isBranch = 1;
        exMemRead = 1; exRegWrite = 1; exRd = 8; idRs = 8;
        cycle("reset_a", C_RST);
        cycle("reset_b", C_RST);
        clear_inputs();
        rst = 0;
        cycle("idle", C_RUN);

        // Load-use: one bubble, then RUN with stallCycles=1
        exMemRead = 1; exRegWrite = 1; exRd = 8; idRs = 8;
        cycle("loaduse_bubble", C_BUB);
        clear_inputs();
        idRs = 8; memRd = 8; memMemRead = 1; memRegWrite = 1;
        cycle("loaduse_resume", C_RUN);
        clear_inputs();

        // Forwarding priority and $0 handling
        memRd = 5; wbRd = 5; exRs = 5; exRt = 5; memRegWrite = 1; wbRegWrite = 1;
        cycle("fwd_mem_wins", C_RUN, 2'd2, 2'd2);
        memRegWrite = 0;
        cycle("fwd_wb", C_RUN, 2'd1, 2'd1);
        exRs = 0;
        cycle("fwd_rs_zero", C_RUN, 2'd0, 2'd1);
        memRegWrite = 1; memRd = 0; exRs = 5; exRt = 0;
        cycle("fwd_memrd_zero", C_RUN, 2'd1, 2'd0);
        clear_inputs();

        // Load into $0 is never a hazard
        exMemRead = 1; exRd = 0; idRs = 0;
        cycle("load_r0", C_RUN);
        clear_inputs();

        // Branch on ALU result: one bubble, branch ignored, then flush once
        idIsBranch = 1; isBranch = 1; idRt = 3; exRd = 3; exRegWrite = 1;
        cycle("br_alu_bubble", C_BUB);
        clear_inputs();
        idIsBranch = 1; isBranch = 1; idRt = 3;
        cycle("br_alu_flush", C_FLUSH);
        clear_inputs();
        cycle("br_alu_after", C_RUN);

        // Branch on load in EX: exactly two bubbles, then taken branch flushes
        idIsBranch = 1; isBranch = 1; idRs = 9; exRd = 9; exMemRead = 1; exRegWrite = 1;
        cycle("br_load_b1", C_BUB);
        clear_inputs();
        idIsBranch = 1; isBranch = 1; idRs = 9; memRd = 9; memMemRead = 1;
        cycle("br_load_b2", C_BUB);
        clear_inputs();
        idIsBranch = 1; isBranch = 1; idRs = 9; wbRd = 9; wbRegWrite = 1;
        cycle("br_load_flush", C_FLUSH);
        clear_inputs();
        cycle("br_load_after", C_RUN);

        // Branch on load in MEM: one bubble
        idIsBranch = 1; idRs = 4; memRd = 4; memMemRead = 1;
        cycle("br_memload_bubble", C_BUB);
        clear_inputs();
        idIsBranch = 1; idRs = 4;
        cycle("br_memload_resume", C_RUN);
        clear_inputs();

        // Jump without hazard flushes
        jump = 1;
        cycle("jump_flush", C_FLUSH);
        clear_inputs();

        // Memory wait in the middle of a two-bubble stall
        idIsBranch = 1; idRs = 9; exRd = 9; exMemRead = 1; exRegWrite = 1;
        cycle("mw_stall_entry", C_BUB);
        clear_inputs();
        idIsBranch = 1; isBranch = 1; idRs = 9; memReq = 1; memReady = 0;
        cycle("mw_freeze1", C_FRZ);
        cycle("mw_freeze2", C_FRZ);
        cycle("mw_freeze3", C_FRZ);
        memReady = 1; isBranch = 0;
        cycle("mw_last_bubble", C_BUB);
        memReq = 0;
        cycle("mw_run", C_RUN);
        clear_inputs();

        // Reset during MEMWAIT aborts it and clears the stall count
        memReq = 1; memReady = 0;
        cycle("rst_mw_freeze1", C_FRZ);
        cycle("rst_mw_freeze2", C_FRZ);
        rst = 1;
        cycle("rst_mw_reset", C_RST);
        rst = 0;
        clear_inputs();
        cycle("rst_mw_run", C_RUN);

        // Long freeze saturates the stall count
        memReq = 1; memReady = 0;
        for (int i = 0; i < 70000; i++) cycle("sat_freeze", C_FRZ);
        clear_inputs();
        cycle("sat_run_a", C_RUN);
        cycle("sat_run_b", C_RUN);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
